// File: rtl/display_mux.sv
// display_mux: captures a value, converts it to decimal/hex seven-segment glyphs
// and scans them across DIGITS active-low multiplexed digits.
module display_mux #(
    parameter int DATA_W      = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1024
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              load,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic [7:0]        segments,
    output logic [DIGITS-1:0] digit
);
    localparam int BCD_N = (DATA_W + 2) / 3;
    localparam int HEX_N = (DATA_W + 3) / 4;
    localparam int MAXN  = (DIGITS > BCD_N) ? ((DIGITS > HEX_N) ? DIGITS : HEX_N)
                                            : ((BCD_N > HEX_N) ? BCD_N : HEX_N);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0]  bin;
    logic [4*BCD_N-1:0] bcd, bcd_adj;
    logic [4*MAXN-1:0]  bcd_pad, hex_pad;
    logic [BIT_W-1:0]   bit_cnt;
    logic [1:0]         mode_q, pend_mode, src_mode;
    logic               neg, pend_v, start, src_neg, src_dec;
    logic [DATA_W-1:0]  pend_data, src_data, src_mag;
    logic [7:0]         disp [DIGITS];
    logic [7:0]         img [DIGITS];
    logic [CNT_W-1:0]   ref_cnt;
    logic [IDX_W-1:0]   idx;
    logic               wrap, last_bit;
    int                 msd;

    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    assign busy     = state != IDLE;
    assign last_bit = bit_cnt == BIT_W'(DATA_W - 1);
    // A load during COMMIT is newer than anything pending, so it wins.
    assign start    = (state == IDLE && load) || (state == COMMIT && (load || pend_v));
    assign src_data = (state == COMMIT && !load) ? pend_data : data;
    assign src_mode = (state == COMMIT && !load) ? pend_mode : mode;
    assign src_neg  = src_mode == 2'b01 && src_data[DATA_W-1];
    assign src_mag  = src_neg ? -src_data : src_data;
    assign src_dec  = !src_mode[1];

    always_comb begin
        state_nx = state == IDLE    ? (load ? (src_dec ? CONVERT : COMMIT) : IDLE) :
                   state == CONVERT ? (last_bit ? COMMIT : CONVERT) :
                                      (start ? (src_dec ? CONVERT : COMMIT) : IDLE);
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            pend_v    <= 1'b0;
            pend_data <= '0;
            pend_mode <= '0;
        end else if (state == COMMIT) begin
            pend_v <= 1'b0;
        end else if (state == CONVERT && load) begin
            pend_v    <= 1'b1;
            pend_data <= data;
            pend_mode <= mode;
        end
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_N; i++)
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            bin     <= '0;
            bcd     <= '0;
            neg     <= 1'b0;
            mode_q  <= 2'b11;
            bit_cnt <= '0;
        end else if (start) begin
            bin     <= src_mag;
            bcd     <= '0;
            neg     <= src_neg;
            mode_q  <= src_mode;
            bit_cnt <= '0;
        end else if (state == CONVERT) begin
            bcd     <= (bcd_adj << 1) | (4*BCD_N)'(bin[DATA_W-1]);
            bin     <= bin << 1;
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign bcd_pad = (4*MAXN)'(bcd);
    assign hex_pad = (4*MAXN)'(bin);

    always_comb begin
        msd = 0;
        for (int i = 0; i < BCD_N; i++)
            if (bcd[4*i +: 4] != 4'd0) msd = i;
    end

    // Decimal overflow counts the minus sign as a digit.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            img[i] = 8'hFF;
            if (mode_q == 2'b10)
                img[i] = (i < HEX_N) ? seg7(hex_pad[4*i +: 4]) : 8'hFF;
            else if (mode_q != 2'b11)
                img[i] = (msd + 1 + int'(neg) > DIGITS) ? 8'hBF :
                         (i <= msd) ? seg7(bcd_pad[4*i +: 4]) :
                         (neg && i == msd + 1) ? 8'hBF : 8'hFF;
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DIGITS; i++) disp[i] <= 8'hFF;
        end else if (state == COMMIT) begin
            for (int i = 0; i < DIGITS; i++) disp[i] <= img[i];
        end
    end

    assign wrap = ref_cnt == CNT_W'(REFRESH_DIV - 1);

    // digit and segments are registered together so they always agree.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            ref_cnt  <= '0;
            idx      <= '0;
            digit    <= '1;
            segments <= 8'hFF;
        end else begin
            ref_cnt  <= wrap ? '0 : ref_cnt + 1'b1;
            idx      <= !wrap ? idx : (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            digit    <= ~(DIGITS'(1) << idx);
            segments <= disp[idx];
        end
    end
endmodule
